// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter in front of a synchronous-read RAM; every access takes two cycles.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default is fixed priority, r0 wins).
module dmem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic        r1_req,
  input  logic        r0_we,
  input  logic        r1_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r0_wdata,
  input  logic [31:0] r1_wdata,
  output logic        r0_gnt,
  output logic        r1_gnt,
  output logic        r0_rvalid,
  output logic        r1_rvalid,
  output logic [31:0] r0_rdata,
  output logic [31:0] r1_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned DW = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;   // 0 = r0, 1 = r1
  logic   rd_q, rd_d;         // latched access was a read
  logic   pick_r1;            // arbitration winner when any request is present

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;       // most recently granted requester

  // On a tie, the requester not granted last time wins.
  always_comb pick_r1 = r1_req && (!r0_req || !last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end
`else
  always_comb pick_r1 = r1_req && !r0_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rd_q    <= rd_d;
    end
  end

  // Next state and all outputs; everything is forced quiet while rst is high.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rd_d      = rd_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    r0_gnt    = 1'b0;
    r1_gnt    = 1'b0;
    r0_rvalid = 1'b0;
    r1_rvalid = 1'b0;
    r0_rdata  = DW'(0);
    r1_rdata  = DW'(0);
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = DW'(0);
    mem_wdata = DW'(0);
    busy      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rst && (r0_req || r1_req)) begin
          mem_en  = 1'b1;
          state_d = WAIT;
          owner_d = pick_r1;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = pick_r1;
`endif
          if (pick_r1) begin
            r1_gnt    = 1'b1;
            mem_we    = r1_we;
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
            rd_d      = !r1_we;
          end else begin
            r0_gnt    = 1'b1;
            mem_we    = r0_we;
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
            rd_d      = !r0_we;
          end
        end
      end
      WAIT: begin
        state_d = IDLE;
        busy    = !rst;
        // RAM read data lands this cycle; route it to the owner only.
        if (!rst && rd_q) begin
          if (owner_q) begin
            r1_rvalid = 1'b1;
            r1_rdata  = mem_rdata;
          end else begin
            r0_rvalid = 1'b1;
            r0_rdata  = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter; expectations follow ARB_ROUND_ROBIN_EN when defined.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r1_req, r0_we, r1_we;
  logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
    .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    r0_req = 1'b0; r1_req = 1'b0; r0_we = 1'b0; r1_we = 1'b0;
    r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
    mem_rdata = '0;

    // Reset holds everything quiet even with a request pending
    #2;
    r0_req = 1'b1;
    #1;
    chk("rst_r0_gnt", 32'(r0_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_busy",   32'(busy),   32'd0);
    r0_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Idle with no requests
    tick();
    chk("idle_mem_en", 32'(mem_en), 32'd0);
    chk("idle_gnt", 32'({r0_gnt, r1_gnt}), 32'd0);
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // r0 read of 0x10
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h10;
    #1;
    chk("rd_r0_gnt",   32'(r0_gnt), 32'd1);
    chk("rd_r1_gnt",   32'(r1_gnt), 32'd0);
    chk("rd_mem_en",   32'(mem_en), 32'd1);
    chk("rd_mem_we",   32'(mem_we), 32'd0);
    chk("rd_mem_addr", mem_addr,    32'h10);
    tick();
    r0_req = 1'b0; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_r0_rvalid", 32'(r0_rvalid), 32'd1);
    chk("rd_r0_rdata",  r0_rdata,       32'hDEADBEEF);
    chk("rd_r1_rvalid", 32'(r1_rvalid), 32'd0);
    chk("rd_r1_rdata",  r1_rdata,       32'h0);
    chk("rd_busy",      32'(busy),      32'd1);
    chk("rd_wait_en",   32'(mem_en),    32'd0);
    tick();
    mem_rdata = 32'h0;
    #1;
    chk("rd_done_rvalid", 32'(r0_rvalid), 32'd0);
    chk("rd_done_busy",   32'(busy),      32'd0);

    // r1 write of 0x12345678 to 0x20
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h20; r1_wdata = 32'h12345678;
    #1;
    chk("wr_r1_gnt",    32'(r1_gnt), 32'd1);
    chk("wr_r0_gnt",    32'(r0_gnt), 32'd0);
    chk("wr_mem_we",    32'(mem_we), 32'd1);
    chk("wr_mem_addr",  mem_addr,    32'h20);
    chk("wr_mem_wdata", mem_wdata,   32'h12345678);
    tick();
    r1_req = 1'b0; r1_we = 1'b0; mem_rdata = 32'hAAAA5555;
    #1;
    chk("wr_busy",      32'(busy),      32'd1);
    chk("wr_r1_rvalid", 32'(r1_rvalid), 32'd0);
    chk("wr_r1_rdata",  r1_rdata,       32'h0);
    chk("wr_r0_rvalid", 32'(r0_rvalid), 32'd0);
    tick();
    mem_rdata = 32'h0;

    // Both requesters hold reads for six cycles
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h100;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h200;
    #1;
    chk("tie0_r0_gnt",  32'(r0_gnt), 32'd1);
    chk("tie0_r1_gnt",  32'(r1_gnt), 32'd0);
    chk("tie0_addr",    mem_addr,    32'h100);
    tick();
    mem_rdata = 32'h11111111;
    #1;
    chk("tie1_gnt",       32'({r0_gnt, r1_gnt}), 32'd0);
    chk("tie1_r0_rvalid", 32'(r0_rvalid),        32'd1);
    chk("tie1_r0_rdata",  r0_rdata,              32'h11111111);
    chk("tie1_r1_rvalid", 32'(r1_rvalid),        32'd0);
    tick();
    #1;
    chk("tie2_r0_gnt", 32'(r0_gnt), RR ? 32'd0 : 32'd1);
    chk("tie2_r1_gnt", 32'(r1_gnt), RR ? 32'd1 : 32'd0);
    chk("tie2_addr",   mem_addr,    RR ? 32'h200 : 32'h100);
    tick();
    mem_rdata = 32'h22222222;
    #1;
    chk("tie3_r1_rvalid", 32'(r1_rvalid), RR ? 32'd1 : 32'd0);
    chk("tie3_r0_rvalid", 32'(r0_rvalid), RR ? 32'd0 : 32'd1);
    chk("tie3_r1_rdata",  r1_rdata,       RR ? 32'h22222222 : 32'h0);
    tick();
    #1;
    chk("tie4_r0_gnt", 32'(r0_gnt), 32'd1);
    chk("tie4_r1_gnt", 32'(r1_gnt), 32'd0);
    tick();
    r0_req = 1'b0; r1_req = 1'b0; mem_rdata = 32'h0;
    tick();

    // Reset in the middle of a read's WAIT cycle
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h40;
    #1;
    chk("rstw_gnt", 32'(r0_gnt), 32'd1);
    tick();
    r0_req = 1'b0; mem_rdata = 32'hCAFEF00D;
    #2;
    rst = 1'b1;
    #1;
    chk("rstw_rvalid", 32'(r0_rvalid), 32'd0);
    chk("rstw_rdata",  r0_rdata,       32'h0);
    chk("rstw_busy",   32'(busy),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstw_rel_rvalid", 32'(r0_rvalid), 32'd0);
    chk("rstw_rel_busy",   32'(busy),      32'd0);
    tick();
    chk("rstw_post_rvalid", 32'(r0_rvalid), 32'd0);
    mem_rdata = 32'h0;
    r0_req = 1'b1; r0_addr = 32'h44;
    #1;
    chk("rstw_next_gnt",  32'(r0_gnt), 32'd1);
    chk("rstw_next_addr", mem_addr,    32'h44);
    tick();
    r0_req = 1'b0; mem_rdata = 32'h0BADC0DE;
    #1;
    chk("rstw_next_rvalid", 32'(r0_rvalid), 32'd1);
    chk("rstw_next_rdata",  r0_rdata,       32'h0BADC0DE);
    tick();
    mem_rdata = 32'h0;

    // r1 raises a write during WAIT and holds it
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h50;
    #1;
    chk("lw_r0_gnt", 32'(r0_gnt), 32'd1);
    tick();
    r0_req = 1'b0;
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h60; r1_wdata = 32'h00005A5A;
    mem_rdata = 32'h00000077;
    #1;
    chk("lw_wait_r1_gnt",  32'(r1_gnt),    32'd0);
    chk("lw_wait_mem_en",  32'(mem_en),    32'd0);
    chk("lw_wait_r0_rdata", r0_rdata,      32'h77);
    tick();
    mem_rdata = 32'h0;
    #1;
    chk("lw_idle_r1_gnt",  32'(r1_gnt), 32'd1);
    chk("lw_idle_addr",    mem_addr,    32'h60);
    chk("lw_idle_mem_we",  32'(mem_we), 32'd1);
    tick();
    r1_req = 1'b0; r1_we = 1'b0;
    #1;
    chk("lw_w_busy",      32'(busy),      32'd1);
    chk("lw_w_r1_rvalid", 32'(r1_rvalid), 32'd0);
    tick();
    chk("lw_end_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports r0_req, r1_req  input  1  access request; r0 = CPU data port, r1 = loader/debug port.
REQ-004 SHALL have ports r0_we, r1_we  input  1  1 = write, 0 = read.
REQ-005 SHALL have ports r0_addr, r1_addr  input  32  word address.
REQ-006 SHALL have ports r0_wdata, r1_wdata  input  32  write data.
REQ-007 SHALL have ports r0_gnt, r1_gnt  output  1  access accepted this cycle.
REQ-008 SHALL have ports r0_rvalid, r1_rvalid  output  1  read data valid, one-cycle pulse.
REQ-009 SHALL have ports r0_rdata, r1_rdata  output  32  read data; 0 whenever the matching rvalid is 0.
REQ-010 SHALL have ports mem_en, mem_we  output  1  RAM enable / write enable.
REQ-011 SHALL have ports mem_addr, mem_wdata  output  32  RAM address / write data.
REQ-012 SHALL have port mem_rdata  input  32  synchronous-read RAM data, valid the cycle after mem_en with mem_we=0.
REQ-013 SHALL have port busy  output  1  high while state is WAIT.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, WAIT.
REQ-015 In IDLE with at least one req high, SHALL combinationally assert exactly one gnt, drive mem_en=1, and drive mem_we/mem_addr/mem_wdata from the granted requester in the same cycle.
REQ-016 On that edge, SHALL latch owner and read flag, and move to WAIT.
REQ-017 In IDLE with no req, SHALL hold all gnt, mem_en and mem_we at 0, and remain in IDLE.
REQ-018 In WAIT, SHALL assert no gnt and hold mem_en at 0.
REQ-019 In WAIT, if the latched access was a read, SHALL pulse rvalid of the owner and pass mem_rdata to that owner's rdata.
REQ-020 From WAIT, SHALL always return to IDLE on the next edge.
REQ-021 Every access SHALL take exactly 2 cycles: gnt at cycle T, read data at T+1, and the next grant no earlier than T+2.
REQ-022 Writes SHALL complete at grant and SHALL produce no rvalid.
REQ-023 A requester SHALL hold req, we, addr and wdata stable until its gnt; the arbiter SHALL NOT buffer ungranted requests.
REQ-024 A req dropped before gnt SHALL be ignored with no side effects.
REQ-025 On simultaneous requests, the winner SHALL be selected per REQ-029/REQ-030.
REQ-026 Outputs of the non-granted or non-owner requester SHALL be 0.

Reset
REQ-027 Asserting rst SHALL immediately force state=IDLE and clear owner, read flag and last_owner (last_owner=1).
REQ-028 While rst is high, all gnt, rvalid, rdata, mem_en, mem_we and busy outputs SHALL be 0; a read in flight during reset SHALL be discarded with no rvalid after release.

Configuration
REQ-029 With macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests, SHALL grant the requester not granted most recently (last_owner register, updated at each grant); after reset, r0 wins the first tie.
REQ-030 Without ARB_ROUND_ROBIN_EN: SHALL use fixed priority, r0 always wins ties; the last_owner register SHALL be absent.

Verification
REQ-031 SHALL cover: r0 read of addr 0x10 with RAM returning 0xDEADBEEF -> r0_gnt=1 at T, r0_rvalid=1 with r0_rdata=0xDEADBEEF at T+1, r1 outputs 0.
REQ-032 SHALL cover: r1 write addr 0x20, data 0x12345678 -> r1_gnt=1 and mem_we=1 with mem_addr=0x20 at T, busy=1 at T+1, no rvalid.
REQ-033 SHALL cover: r0 and r1 both holding read requests for 6 cycles -> with ARB_ROUND_ROBIN_EN, grant order r0, r1, r0 at cycles 0, 2, 4; without it, r0, r0, r0.
REQ-034 SHALL cover: rst asserted mid-cycle during WAIT of an r0 read -> r0_rvalid stays 0, state returns to IDLE, and the first access after release is granted normally.
REQ-035 SHALL cover: r1_req raised during WAIT and held -> r1_gnt at the first IDLE cycle, never during WAIT.
